dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS phase-accumulator core. It latches a sweep configuration on `start`, then steps the tuning word from a start frequency by a fixed increment. Each frequency point is held for a programmable dwell time. The block drives the `freq_data` and `phase_data` inputs of the DDS core directly and reports progress to the register/control layer through `busy`, `step_tick` and `done`.

## Interface
- `FREQ_WIDTH`, 32: tuning-word width; matches the DDS accumulator.
- `PHASE_WIDTH`, 12: phase-offset width; matches the DDS ROM address.
- `CNT_WIDTH`, 16: width of the point-count and dwell fields.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a sweep; honoured only in IDLE.
- `abort`  in  1  terminates a running sweep.
- `cfg_start_freq`  in  FREQ_WIDTH  tuning word of the first point.
- `cfg_step_freq`  in  FREQ_WIDTH  increment added per point, modulo 2^FREQ_WIDTH.
- `cfg_num_pts`  in  CNT_WIDTH  number of frequency points N; 0 is treated as 1.
- `cfg_dwell`  in  CNT_WIDTH  cycles per point D; 0 is treated as 1.
- `cfg_phase`  in  PHASE_WIDTH  phase offset applied for the whole sweep.
- `cfg_pingpong`  in  1  present only with `DDS_SWEEP_PINGPONG_EN`.
- `freq_data`  out  FREQ_WIDTH  registered tuning word to the DDS.
- `phase_data`  out  PHASE_WIDTH  registered phase offset to the DDS.
- `busy`  out  1  high while a sweep is running.
- `step_tick`  out  1  one-cycle pulse in the first cycle of each point.
- `done`  out  1  one-cycle pulse on normal completion.

## Operation
- **States:** IDLE, DWELL, DONE.
- **IDLE:** on `start`, latch all `cfg_*` inputs and go to DWELL. In DWELL, load `freq_data`=start, `phase_data`=cfg_phase, point index 0, dwell counter 0.
- **DWELL:** the dwell counter increments each cycle. When it reaches D-1:
  - if the point index is below N-1, add the step to `freq_data`, increment the index, clear the counter and pulse `step_tick`;
  - otherwise go to DONE.
- **DONE:** lasts one cycle with `done`=1, then returns to IDLE.
- **Outputs after a sweep:** `freq_data` and `phase_data` hold their last values after DONE or abort. They are never zeroed except by reset.
- **Configuration changes:** changes to `cfg_*` during a sweep have no effect; only the values latched at `start` are used.
- **`start` while busy:** ignored.
- **Abort:** `abort` in DWELL goes to IDLE on the next edge. No `done` pulse is produced, and `freq_data` holds. `abort` has priority over dwell expiry in the same cycle. `abort` in IDLE or DONE is ignored.
- **Frequency wrap-around:** the frequency add wraps silently, with no saturation.
- **Reset mid-sweep:** returns to IDLE with all outputs at their reset values.

## Timing
- **Reset values:** `freq_data`=0, `phase_data`=0, `busy`=0, `step_tick`=0, `done`=0, state IDLE.
- **Start latency:** with `start` sampled at edge t, the first point is on the outputs after edge t+1.
- **Signals at edge t+1:** `busy`=1 and `step_tick`=1.
- **Point k (0-based):** valid from edge t+1+k·D for exactly D cycles.
- **`step_tick`:** one-cycle pulse at each point boundary.
- **Completion:** `done`=1 and `busy`=0 in the cycle after edge t+1+N·D.
- **Total busy time:** N·D cycles.
- **Next start:** `start` is accepted again in the cycle following `done`.

## Configuration
- **`DDS_SWEEP_PINGPONG_EN` defined:**
  - `cfg_pingpong` exists and is latched at `start`.
  - If it is set and N>1, after point N-1 the sweep reverses, subtracting the step, back down to the start frequency. This gives 2N-1 points and (2N-1)·D busy cycles.
  - `step_tick` fires at every point.
  - `done` pulses after the final descending point.
- **`DDS_SWEEP_PINGPONG_EN` not defined:**
  - The port is absent and the direction logic is not built.
  - The sweep is single-direction only.

## Structure
- **Shared package `dds_pkg`:**
  - state enum (IDLE/DWELL/DONE);
  - default widths `FREQ_W`=32, `PHASE_W`=12, `CNT_W`=16;
  - the direction enum UP/DOWN, used under the macro.
- **Sub-module `dds_dwell_timer`:**
  - loadable up-counter with a terminal-count output for D-1;
  - clear input; 0→1 clamp applied inside.
- **Top level:** the FSM, latched configuration, point index and frequency adder stay in the top.

## Test plan
- **Basic sweep:** start=1000, step=250, N=4, D=3. Expect `freq_data` 1000,1000,1000,1250×3,1500×3,1750×3. Expect `step_tick` at cycles 1,4,7,10, `done` at cycle 13, and `busy` high for 12 cycles.
- **Zero clamps:** N=0, D=0. Expect a single point of 1 cycle, then `done`; `freq_data`=start.
- **Wrap-around:** start=0xFFFF_FF00, step=0x200, N=2. The second point must be 0x0000_0100.
- **Abort:** abort during point 2 of a 4-point sweep. Expect IDLE next cycle, no `done`, `freq_data` holding point 2. Abort coincident with the final dwell expiry also gives no `done`.
- **Ignored start and frozen config:** `start` pulsed mid-sweep, and `cfg_step_freq` changed mid-sweep. The sweep must be unaffected.
- **Ping-pong (with macro):** `cfg_pingpong`=1, start=100, step=10, N=3, D=1. Expect 100,110,120,110,100, then `done`. With the macro off, 100,110,120.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS sweep controller.
// The direction enum is only used when DDS_SWEEP_PINGPONG_EN is defined.
package dds_pkg;

    localparam int FREQ_W  = 32;
    localparam int PHASE_W = 12;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } dds_state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dds_dir_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell timer: up-counter that flags the last cycle of a frequency point.
// The dwell length is captured on load; a length of 0 behaves as 1.
module dds_dwell_timer
    import dds_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] dwell,
    input  logic                 clr,
    input  logic                 en,
    output logic                 tc
);

    logic [CNT_WIDTH-1:0] limit;
    logic [CNT_WIDTH-1:0] count;

    // Capture the clamped dwell length and advance the cycle count within a point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit <= CNT_WIDTH'(1);
            count <= '0;
        end else begin
            if (load) begin
                limit <= (dwell == '0) ? CNT_WIDTH'(1) : dwell;
            end
            if (load || clr) begin
                count <= '0;
            end else if (en) begin
                count <= count + CNT_WIDTH'(1);
            end
        end
    end

    assign tc = (count == (limit - CNT_WIDTH'(1)));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving the DDS tuning word and phase offset.
// Optional feature: define DDS_SWEEP_PINGPONG_EN to add cfg_pingpong and the
// up-then-down sweep; without it the sweep only ascends.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last point
// DWELL | first cycle loads point 0, then each point is held D cycles
// DONE  | one-cycle completion pulse, then back to IDLE
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FREQ_WIDTH  = FREQ_W,
    parameter int PHASE_WIDTH = PHASE_W,
    parameter int CNT_WIDTH   = CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [FREQ_WIDTH-1:0]  cfg_start_freq,
    input  logic [FREQ_WIDTH-1:0]  cfg_step_freq,
    input  logic [CNT_WIDTH-1:0]   cfg_num_pts,
    input  logic [CNT_WIDTH-1:0]   cfg_dwell,
    input  logic [PHASE_WIDTH-1:0] cfg_phase,
`ifdef DDS_SWEEP_PINGPONG_EN
    input  logic                   cfg_pingpong,
`endif
    output logic [FREQ_WIDTH-1:0]  freq_data,
    output logic [PHASE_WIDTH-1:0] phase_data,
    output logic                   busy,
    output logic                   step_tick,
    output logic                   done
);

    localparam int IDX_W = CNT_WIDTH + 1;

    dds_state_t             state;
    logic                   load_pend;
    logic [FREQ_WIDTH-1:0]  start_q;
    logic [FREQ_WIDTH-1:0]  step_q;
    logic [PHASE_WIDTH-1:0] phase_q;
    logic [IDX_W-1:0]       last_idx_q;
    logic [IDX_W-1:0]       idx;
    logic [CNT_WIDTH-1:0]   n_eff;
    logic [IDX_W-1:0]       last_idx_d;
    logic                   timer_load;
    logic                   timer_clr;
    logic                   timer_en;
    logic                   dwell_tc;
`ifdef DDS_SWEEP_PINGPONG_EN
    dds_dir_t               dir;
    logic [IDX_W-1:0]       turn_idx_q;
`endif

    // Index of the final point, from the clamped point count (2N-2 when reversing).
    always_comb begin
        n_eff      = (cfg_num_pts == '0) ? CNT_WIDTH'(1) : cfg_num_pts;
        last_idx_d = {1'b0, n_eff} - IDX_W'(1);
`ifdef DDS_SWEEP_PINGPONG_EN
        if (cfg_pingpong && (n_eff > CNT_WIDTH'(1))) begin
            last_idx_d = {n_eff, 1'b0} - IDX_W'(2);
        end
`endif
    end

    assign timer_load = (state == IDLE) && start;
    assign timer_en   = (state == DWELL) && !load_pend;
    assign timer_clr  = (state == DWELL) && (load_pend || dwell_tc);

    dds_dwell_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_dwell_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .dwell (cfg_dwell),
        .clr   (timer_clr),
        .en    (timer_en),
        .tc    (dwell_tc)
    );

    // Sweep FSM: configuration capture, point stepping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            load_pend  <= 1'b0;
            start_q    <= '0;
            step_q     <= '0;
            phase_q    <= '0;
            last_idx_q <= '0;
            idx        <= '0;
            freq_data  <= '0;
            phase_data <= '0;
            busy       <= 1'b0;
            step_tick  <= 1'b0;
            done       <= 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
            dir        <= UP;
            turn_idx_q <= '0;
`endif
        end else begin
            step_tick <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        start_q    <= cfg_start_freq;
                        step_q     <= cfg_step_freq;
                        phase_q    <= cfg_phase;
                        last_idx_q <= last_idx_d;
                        load_pend  <= 1'b1;
                        state      <= DWELL;
`ifdef DDS_SWEEP_PINGPONG_EN
                        turn_idx_q <= {1'b0, n_eff} - IDX_W'(1);
`endif
                    end
                end
                DWELL: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        load_pend <= 1'b0;
                    end else if (load_pend) begin
                        load_pend  <= 1'b0;
                        freq_data  <= start_q;
                        phase_data <= phase_q;
                        idx        <= '0;
                        busy       <= 1'b1;
                        step_tick  <= 1'b1;
`ifdef DDS_SWEEP_PINGPONG_EN
                        dir        <= UP;
`endif
                    end else if (dwell_tc) begin
                        if (idx < last_idx_q) begin
                            idx       <= idx + IDX_W'(1);
                            step_tick <= 1'b1;
`ifdef DDS_SWEEP_PINGPONG_EN
                            // Reversal happens on the step leaving the top point.
                            if ((dir == DOWN) || (idx == turn_idx_q)) begin
                                dir       <= DOWN;
                                freq_data <= freq_data - step_q;
                            end else begin
                                freq_data <= freq_data + step_q;
                            end
`else
                            freq_data <= freq_data + step_q;
`endif
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: vector table of whole sweeps plus hand sequences
// for abort, reset and start-timing corner cases.
`timescale 1ns/1ps
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] cfg_start_freq;
    logic [31:0] cfg_step_freq;
    logic [15:0] cfg_num_pts;
    logic [15:0] cfg_dwell;
    logic [11:0] cfg_phase;
`ifdef DDS_SWEEP_PINGPONG_EN
    logic        cfg_pingpong;
`endif
    logic [31:0] freq_data;
    logic [11:0] phase_data;
    logic        busy;
    logic        step_tick;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] sf;
        logic [31:0] st;
        logic [15:0] n;
        logic [15:0] d;
        logic [11:0] ph;
        logic        pp;
        int          disturb;
        int          exp_done;
        int          exp_busy;
        int          exp_ticks;
        logic [31:0] exp_last;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] fseq [0:63];
    logic        tseq [0:63];
    logic [31:0] exp_basic [1:12];
    logic [31:0] exp_pp [$];

    dds_sweep_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .cfg_start_freq (cfg_start_freq),
        .cfg_step_freq  (cfg_step_freq),
        .cfg_num_pts    (cfg_num_pts),
        .cfg_dwell      (cfg_dwell),
        .cfg_phase      (cfg_phase),
`ifdef DDS_SWEEP_PINGPONG_EN
        .cfg_pingpong   (cfg_pingpong),
`endif
        .freq_data      (freq_data),
        .phase_data     (phase_data),
        .busy           (busy),
        .step_tick      (step_tick),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [31:0] sf, input logic [31:0] st, input logic [15:0] n,
                           input logic [15:0] d, input logic [11:0] ph, input logic pp);
        cfg_start_freq = sf;
        cfg_step_freq  = st;
        cfg_num_pts    = n;
        cfg_dwell      = d;
        cfg_phase      = ph;
`ifdef DDS_SWEEP_PINGPONG_EN
        cfg_pingpong   = pp;
`else
        if (pp) begin
            cfg_phase = ph;
        end
`endif
    endtask

    // Called #1 after an edge; start is sampled at the next edge (cycle 0).
    task automatic run_sweep(input vec_t v, output int done_cyc, output int busy_cnt, output int tick_cnt);
        done_cyc = -1;
        busy_cnt = 0;
        tick_cnt = 0;
        set_cfg(v.sf, v.st, v.n, v.d, v.ph, v.pp);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
            if (c == v.disturb) begin
                start = 1'b1;
                set_cfg(32'h9, 32'h1, 16'd9, 16'd7, 12'h555, 1'b0);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (c < 64) begin
                fseq[c] = freq_data;
                tseq[c] = step_tick;
            end
            if (busy)      busy_cnt++;
            if (step_tick) tick_cnt++;
            if (done)      done_cyc = c;
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, bc, tc;
        int seen_done;

        vecs[0] = '{32'd1000, 32'd250, 16'd4, 16'd3, 12'h123, 1'b0, 0, 13, 12, 4, 32'd1750};
        vecs[1] = '{32'd5555, 32'd7, 16'd0, 16'd0, 12'hABC, 1'b0, 0, 2, 1, 1, 32'd5555};
        vecs[2] = '{32'hFFFF_FF00, 32'h200, 16'd2, 16'd1, 12'h000, 1'b0, 0, 3, 2, 2, 32'h0000_0100};
        vecs[3] = '{32'd42, 32'd9, 16'd1, 16'd4, 12'hFFF, 1'b0, 0, 5, 4, 1, 32'd42};
        vecs[4] = '{32'd0, 32'd3, 16'd5, 16'd1, 12'h001, 1'b0, 0, 6, 5, 5, 32'd12};
`ifdef DDS_SWEEP_PINGPONG_EN
        vecs[5] = '{32'd100, 32'd10, 16'd3, 16'd1, 12'h010, 1'b1, 0, 6, 5, 5, 32'd100};
        exp_pp  = '{32'd100, 32'd110, 32'd120, 32'd110, 32'd100};
`else
        vecs[5] = '{32'd100, 32'd10, 16'd3, 16'd1, 12'h010, 1'b1, 0, 4, 3, 3, 32'd120};
        exp_pp  = '{32'd100, 32'd110, 32'd120};
`endif
        vecs[6] = '{32'd7, 32'd1, 16'd1, 16'd2, 12'h0F0, 1'b1, 0, 3, 2, 1, 32'd7};
        vecs[7] = '{32'd1000, 32'd250, 16'd4, 16'd3, 12'h321, 1'b0, 5, 13, 12, 4, 32'd1750};

        exp_basic = '{32'd1000, 32'd1000, 32'd1000, 32'd1250, 32'd1250, 32'd1250,
                      32'd1500, 32'd1500, 32'd1500, 32'd1750, 32'd1750, 32'd1750};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(32'hDEAD_BEEF, 32'h1, 16'd3, 16'd3, 12'h777, 1'b0);
        #23;
        check("reset_freq",  freq_data, 32'd0);
        check("reset_phase", 32'(phase_data), 32'd0);
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_tick",  32'(step_tick), 32'd0);
        check("reset_done",  32'(done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_freq", freq_data, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_sweep(vecs[i], dc, bc, tc);
            $display("vector %0d: done_cycle=%0d busy=%0d ticks=%0d freq=0x%08h", i, dc, bc, tc, freq_data);
            check($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_done);
            check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_busy);
            check($sformatf("v%0d_ticks", i), tc, vecs[i].exp_ticks);
            check($sformatf("v%0d_last_freq", i), freq_data, vecs[i].exp_last);
            check($sformatf("v%0d_phase", i), 32'(phase_data), 32'(vecs[i].ph));
            if (i == 0) begin
                for (int c = 1; c <= 12; c++) begin
                    check($sformatf("basic_freq_c%0d", c), fseq[c], exp_basic[c]);
                end
                for (int c = 1; c <= 13; c++) begin
                    check($sformatf("basic_tick_c%0d", c), 32'(tseq[c]),
                          (c == 1 || c == 4 || c == 7 || c == 10) ? 32'd1 : 32'd0);
                end
            end
            if (i == 5) begin
                for (int k = 0; k < exp_pp.size(); k++) begin
                    check($sformatf("pingpong_freq_p%0d", k), fseq[k+1], exp_pp[k]);
                end
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("hold_after_done", freq_data, 32'd1750);

        // Abort during point 2 of a 4-point sweep
        set_cfg(32'd1000, 32'd250, 16'd4, 16'd3, 12'h042, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("abort_pre_freq", freq_data, 32'd1500);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_freq", freq_data, 32'd1500);
        seen_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1;
        end
        check("abort_no_done", seen_done, 0);
        check("abort_hold_freq", freq_data, 32'd1500);

        // Abort coincident with the final dwell expiry
        set_cfg(32'd10, 32'd5, 16'd2, 16'd2, 12'h001, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_last_pre_freq", freq_data, 32'd15);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        seen_done = 32'(done);
        check("abort_last_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1;
        end
        check("abort_last_no_done", seen_done, 0);
        check("abort_last_freq", freq_data, 32'd15);

        // start presented in the DONE cycle is not honoured
        set_cfg(32'd77, 32'd1, 16'd1, 16'd1, 12'h002, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("done_cycle_pulse", 32'(done), 32'd1);
        set_cfg(32'd88, 32'd1, 16'd1, 16'd1, 12'h002, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("start_in_done_ignored_busy", 32'(busy), 32'd0);
        check("start_in_done_ignored_freq", freq_data, 32'd77);

        // Reset in the middle of a sweep
        set_cfg(32'd1000, 32'd250, 16'd4, 16'd3, 12'h0AA, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midreset_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check("midreset_freq",  freq_data, 32'd0);
        check("midreset_phase", 32'(phase_data), 32'd0);
        check("midreset_busy",  32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midreset_stays_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
